pc_fetch_unit: RTL and testbench

- IF stage. Owns the program counter and drives the instruction-RAM fetch address.
- Supplies PC+1 to the IF/ID pipeline register.
- Obeys the same two stall sources as IF/ID:
  - ramSlot: the data-memory access occupies the shared RAM.
  - loadSlot: load-use hazard.
- Applies branch/jump redirects resolved in ID.
- Runs a short boot wait after reset before the first fetch.

---
 rtl/pc_fetch_unit.sv | 80 ++++++++
 tb/tb_pc_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: boot wait, stall hold, ID redirects and fetch enable.
// Optional macro PC_FETCH_COUNT_EN adds a wrapping counter of accepted fetches.
module pc_fetch_unit #(
  parameter logic [15:0] PC_START    = 16'h0000,
  parameter int unsigned BOOT_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RSTboot,
  input  logic        ramSlot,
  input  logic        loadSlot,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] pc_fetch,
  output logic [15:0] pc_next_seq,
  output logic        fetch_en,
`ifdef PC_FETCH_COUNT_EN
  output logic [15:0] fetch_count,
`endif
  output logic        booting
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_boot_cnt;
  logic [PC_W-1:0]  r_pc;

  // State, boot counter and PC; redirect outranks both stall sources.
  always_ff @(posedge CLK or negedge RSTboot) begin
    if (!RSTboot) begin
      r_state    <= ST_BOOT;
      r_boot_cnt <= '0;
      r_pc       <= PC_START;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_boot_cnt <= r_boot_cnt + CNT_W'(1);
          if (r_boot_cnt == BOOT_LAST) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (redirect_valid) begin
            r_pc <= redirect_target;
          end else if (!loadSlot && !ramSlot) begin
            r_pc <= r_pc + PC_W'(1);
          end
        end
      endcase
    end
  end

  assign pc_fetch    = r_pc;
  assign pc_next_seq = r_pc + PC_W'(1);
  assign fetch_en    = (r_state == ST_RUN) && !ramSlot;
  assign booting     = (r_state == ST_BOOT);

`ifdef PC_FETCH_COUNT_EN
  logic [15:0] r_fetch_count;

  // Counts only fetches that IF/ID latches (not lost to MEM, not held by load-use).
  always_ff @(posedge CLK or negedge RSTboot) begin
    if (!RSTboot) begin
      r_fetch_count <= '0;
    end else if (r_state == ST_RUN && fetch_en && !loadSlot) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot wait, stalls, redirect priority, wrap, async reset.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        RSTboot;
  logic        ramSlot;
  logic        loadSlot;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] pc_fetch;
  logic [15:0] pc_next_seq;
  logic        fetch_en;
  logic        booting;
`ifdef PC_FETCH_COUNT_EN
  logic [15:0] fetch_count;
  logic [15:0] cnt_before;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_unit #(.PC_START(16'h0000), .BOOT_CYCLES(4)) dut (
    .CLK            (CLK),
    .RSTboot        (RSTboot),
    .ramSlot        (ramSlot),
    .loadSlot       (loadSlot),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pc_fetch       (pc_fetch),
    .pc_next_seq    (pc_next_seq),
    .fetch_en       (fetch_en),
`ifdef PC_FETCH_COUNT_EN
    .fetch_count    (fetch_count),
`endif
    .booting        (booting)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic jump_to(input logic [15:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
  endtask

  task automatic test_reset();
    RSTboot = 1'b0; ramSlot = 1'b0; loadSlot = 1'b0;
    redirect_valid = 1'b0; redirect_target = 16'h0000;
    #12;
    n_tests++;
    if (pc_fetch !== 16'h0000 || fetch_en !== 1'b0 || booting !== 1'b1 || pc_next_seq !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_state pc=%h nxt=%h fe=%b boot=%b exp 0000 0001 0 1", pc_fetch, pc_next_seq, fetch_en, booting);
    end
`ifdef PC_FETCH_COUNT_EN
    n_tests++;
    if (fetch_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_count got=%h exp=0000", fetch_count);
    end
`endif
    @(negedge CLK);
    RSTboot = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (pc_fetch !== 16'h0000 || fetch_en !== 1'b0 || booting !== 1'b1) begin
        n_fail++;
        $display("FAIL boot_edge%0d pc=%h fe=%b boot=%b exp 0000 0 1", k, pc_fetch, fetch_en, booting);
      end
    end
    tick();
    n_tests++;
    if (pc_fetch !== 16'h0000 || fetch_en !== 1'b1 || booting !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_exit pc=%h fe=%b boot=%b exp 0000 1 0", pc_fetch, fetch_en, booting);
    end
    tick();
    n_tests++;
    if (pc_fetch !== 16'h0001) begin
      n_fail++;
      $display("FAIL run_pc1 got=%h exp=0001", pc_fetch);
    end
    tick();
    n_tests++;
    if (pc_fetch !== 16'h0002 || pc_next_seq !== 16'h0003) begin
      n_fail++;
      $display("FAIL run_pc2 pc=%h nxt=%h exp 0002 0003", pc_fetch, pc_next_seq);
    end
  endtask

  task automatic test_load_stall();
    jump_to(16'h0010);
    n_tests++;
    if (pc_fetch !== 16'h0010) begin
      n_fail++;
      $display("FAIL load_setup got=%h exp=0010", pc_fetch);
    end
`ifdef PC_FETCH_COUNT_EN
    cnt_before = fetch_count;
`endif
    loadSlot = 1'b1;
    #1;
    n_tests++;
    if (fetch_en !== 1'b1) begin
      n_fail++;
      $display("FAIL load_fetch_en got=%b exp=1", fetch_en);
    end
    tick();
    loadSlot = 1'b0;
    n_tests++;
    if (pc_fetch !== 16'h0010) begin
      n_fail++;
      $display("FAIL load_hold got=%h exp=0010", pc_fetch);
    end
`ifdef PC_FETCH_COUNT_EN
    n_tests++;
    if (fetch_count !== cnt_before) begin
      n_fail++;
      $display("FAIL load_count got=%h exp=%h", fetch_count, cnt_before);
    end
`endif
    tick();
    n_tests++;
    if (pc_fetch !== 16'h0011) begin
      n_fail++;
      $display("FAIL load_release got=%h exp=0011", pc_fetch);
    end
`ifdef PC_FETCH_COUNT_EN
    n_tests++;
    if (fetch_count !== cnt_before + 16'd1) begin
      n_fail++;
      $display("FAIL load_count_resume got=%h exp=%h", fetch_count, cnt_before + 16'd1);
    end
`endif
  endtask

  task automatic test_ram_stall();
    jump_to(16'h0020);
    ramSlot = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (fetch_en !== 1'b0 || pc_fetch !== 16'h0020) begin
        n_fail++;
        $display("FAIL ram_stall%0d fe=%b pc=%h exp 0 0020", k, fetch_en, pc_fetch);
      end
      tick();
    end
    ramSlot = 1'b0;
    #1;
    n_tests++;
    if (fetch_en !== 1'b1 || pc_fetch !== 16'h0020) begin
      n_fail++;
      $display("FAIL ram_refetch fe=%b pc=%h exp 1 0020", fetch_en, pc_fetch);
    end
    tick();
    n_tests++;
    if (pc_fetch !== 16'h0021) begin
      n_fail++;
      $display("FAIL ram_release got=%h exp=0021", pc_fetch);
    end
  endtask

  task automatic test_both_stalls();
    jump_to(16'h0040);
    ramSlot = 1'b1; loadSlot = 1'b1;
    #1;
    n_tests++;
    if (fetch_en !== 1'b0) begin
      n_fail++;
      $display("FAIL both_fetch_en got=%b exp=0", fetch_en);
    end
    tick();
    ramSlot = 1'b0; loadSlot = 1'b0;
    n_tests++;
    if (pc_fetch !== 16'h0040) begin
      n_fail++;
      $display("FAIL both_hold got=%h exp=0040", pc_fetch);
    end
  endtask

  task automatic test_redirect_priority();
    jump_to(16'h0030);
    ramSlot = 1'b1; loadSlot = 1'b1;
    jump_to(16'h0100);
    ramSlot = 1'b0; loadSlot = 1'b0;
    n_tests++;
    if (pc_fetch !== 16'h0100) begin
      n_fail++;
      $display("FAIL redirect_prio got=%h exp=0100", pc_fetch);
    end
  endtask

  task automatic test_wrap();
    jump_to(16'hFFFF);
    n_tests++;
    if (pc_next_seq !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_next got=%h exp=0000", pc_next_seq);
    end
    tick();
    n_tests++;
    if (pc_fetch !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_pc got=%h exp=0000", pc_fetch);
    end
  endtask

  task automatic test_async_reset();
    jump_to(16'h0055);
    #2;
    RSTboot = 1'b0;
    #1;
    n_tests++;
    if (pc_fetch !== 16'h0000 || fetch_en !== 1'b0 || booting !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset pc=%h fe=%b boot=%b exp 0000 0 1", pc_fetch, fetch_en, booting);
    end
  endtask

  task automatic test_boot_redirect();
    redirect_valid  = 1'b1;
    redirect_target = 16'h1234;
    @(negedge CLK);
    RSTboot = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (pc_fetch !== 16'h0000 || booting !== 1'b1) begin
        n_fail++;
        $display("FAIL boot_redirect_edge%0d pc=%h boot=%b exp 0000 1", k, pc_fetch, booting);
      end
    end
    tick();
    redirect_valid = 1'b0;
    n_tests++;
    if (pc_fetch !== 16'h0000 || fetch_en !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_redirect_first pc=%h fe=%b exp 0000 1", pc_fetch, fetch_en);
    end
    tick();
    n_tests++;
    if (pc_fetch !== 16'h0001) begin
      n_fail++;
      $display("FAIL boot_redirect_next got=%h exp=0001", pc_fetch);
    end
  endtask

  initial begin
    test_reset();
    test_load_stall();
    test_ram_stall();
    test_both_stalls();
    test_redirect_priority();
    test_wrap();
    test_async_reset();
    test_boot_redirect();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
